// File: rtl/csa_final_add_pipe.sv
// Two-stage carry-propagate adder for the multiplier's carry-save tree outputs.
// Produces the 32-bit product, a rounded/saturated Q15 value and a saturation event count.
module csa_final_add_pipe #(
    parameter int unsigned SPLIT    = 16,
    parameter int unsigned SATCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         add_out0,
    input  logic [31:0]         add_out1,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         product,
    output logic [15:0]         q15,
    output logic                q15_sat,
    output logic [SATCNT_W-1:0] sat_cnt
);

    localparam int unsigned HiW = 32 - SPLIT;

    logic                r_s1_valid;
    logic [SPLIT:0]      r_lo;
    logic [HiW-1:0]      r_hi0;
    logic [HiW-1:0]      r_hi1;
    logic                r_out_valid;
    logic [31:0]         r_product;
    logic [15:0]         r_q15;
    logic                r_q15_sat;
    logic [SATCNT_W-1:0] r_sat_cnt;

    logic           w_s2_free;
    logic           w_accept;
    logic           w_advance;
    logic           w_deliver;
    logic [SPLIT:0] w_lo;
    logic [HiW-1:0] w_hi;
    logic [31:0]    w_product;
    logic [17:0]    w_r;
    logic           w_ovf;
    logic [15:0]    w_q15;

    assign w_s2_free = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_accept  = in_valid && in_ready;
    assign w_advance = r_s1_valid && w_s2_free;
    assign w_deliver = r_out_valid && out_ready;

    assign w_lo      = {1'b0, add_out0[SPLIT-1:0]} + {1'b0, add_out1[SPLIT-1:0]};
    assign w_hi      = r_hi0 + r_hi1 + HiW'(r_lo[SPLIT]);
    assign w_product = {w_hi, r_lo[SPLIT-1:0]};

    // (p + 2^14) >>> 15 equals floor(p / 2^15) plus the carry from bit 14.
    assign w_r   = {w_product[31], w_product[31:15]} + {17'b0, w_product[14]};
    assign w_ovf = (w_r[17:15] != 3'b000) && (w_r[17:15] != 3'b111);

    always_comb begin
        w_q15 = w_r[15:0];
        if (w_ovf) begin
            w_q15 = w_r[17] ? 16'h8000 : 16'h7FFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_lo       <= '0;
            r_hi0      <= '0;
            r_hi1      <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_lo       <= w_lo;
                r_hi0      <= add_out0[31:SPLIT];
                r_hi1      <= add_out1[31:SPLIT];
            end else if (w_advance) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_q15       <= '0;
            r_q15_sat   <= 1'b0;
        end else begin
            if (w_advance) begin
                r_out_valid <= 1'b1;
                r_product   <= w_product;
                r_q15       <= w_q15;
                r_q15_sat   <= w_ovf;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (w_deliver && r_q15_sat && (r_sat_cnt != {SATCNT_W{1'b1}})) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign q15       = r_q15;
    assign q15_sat   = r_q15_sat;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_csa_final_add_pipe.sv
// Randomised and directed bench for csa_final_add_pipe against an arithmetic reference model.
module tb_csa_final_add_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] add_out0;
    logic [31:0] add_out1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic [15:0] q15;
    logic        q15_sat;
    logic [15:0] sat_cnt;

    csa_final_add_pipe #(.SPLIT(16), .SATCNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .add_out0  (add_out0),
        .add_out1  (add_out1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .q15       (q15),
        .q15_sat   (q15_sat),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p;
        logic [15:0] q;
        logic        s;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_dlv = 0;
    logic [15:0] exp_cnt = 0;
    logic        acc;
    logic        dlv;
    logic [31:0] last_p;
    logic [15:0] last_q;
    logic        last_s;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sp;
        longint r;
        e.p = a + b;
        sp  = longint'($signed(e.p));
        r   = (sp + 16384) >>> 15;
        if (r > 32767) begin
            e.q = 16'h7FFF;
            e.s = 1'b1;
        end else if (r < -32768) begin
            e.q = 16'h8000;
            e.s = 1'b1;
        end else begin
            e.q = 16'(r);
            e.s = 1'b0;
        end
        return e;
    endfunction

    // Observe handshakes mid-cycle, score deliveries, then advance one clock.
    task automatic step();
        exp_t e;
        @(negedge clk);
        acc = in_valid && in_ready;
        dlv = out_valid && out_ready;
        check("sat_cnt", 64'(sat_cnt), 64'(exp_cnt));
        if (dlv) begin
            n_dlv++;
            last_p = product;
            last_q = q15;
            last_s = q15_sat;
            if (exp_q.size() == 0) begin
                check("stale_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("product", 64'(product), 64'(e.p));
                check("q15", 64'(q15), 64'(e.q));
                check("q15_sat", 64'(q15_sat), 64'(e.s));
                if (e.s && exp_cnt != 16'hFFFF) exp_cnt++;
            end
        end
        if (acc) exp_q.push_back(model(add_out0, add_out1));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Single transfer into an idle pipe with out_ready high; also checks latency.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b);
        int k;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        add_out0  = a;
        add_out1  = b;
        k = 0;
        do begin
            step();
            k++;
        end while (!acc && k < 20);
        check("accept_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
        check("lat_n", 64'(out_valid), 64'd0);
        step();
        check("lat_n1", 64'(out_valid), 64'd1);
        drain();
    endtask

    initial begin
        int          acc_cnt;
        int          idx;
        int          d0;
        logic [31:0] bp_a [4];

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        add_out0  = '0;
        add_out1  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        check("rst_q15", 64'(q15), 64'd0);
        check("rst_q15_sat", 64'(q15_sat), 64'd0);
        check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        run_one(32'h3FFF0001, 32'h0);
        check("d1_product", 64'(last_p), 64'h3FFF0001);
        check("d1_q15", 64'(last_q), 64'h7FFE);
        check("d1_sat", 64'(last_s), 64'd0);
        run_one(32'hFFFFFFFF, 32'h00000001);
        check("d2_product", 64'(last_p), 64'h0);
        check("d2_q15", 64'(last_q), 64'h0);
        run_one(32'h40000000, 32'h0);
        check("d3_q15", 64'(last_q), 64'h7FFF);
        check("d3_sat", 64'(last_s), 64'd1);
        check("d3_sat_cnt", 64'(sat_cnt), 64'd1);
        run_one(32'hC0008000, 32'h0);
        check("d4_q15", 64'(last_q), 64'h8001);
        check("d4_sat", 64'(last_s), 64'd0);
        run_one(32'h00004000, 32'h0);
        check("d5_q15", 64'(last_q), 64'h0001);

        // Backpressure: two accepts fill the pipe, then four results in consecutive cycles.
        bp_a[0] = 32'h00012345; bp_a[1] = 32'h7FFF0000;
        bp_a[2] = 32'hFFFE8000; bp_a[3] = 32'h00ABC000;
        out_ready = 1'b0;
        idx       = 0;
        acc_cnt   = 0;
        in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            add_out0 = bp_a[idx];
            add_out1 = 32'h5;
            step();
            if (acc) begin
                acc_cnt++;
                idx++;
            end
        end
        check("bp_accepts", 64'(acc_cnt), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        d0 = n_dlv;
        for (int c = 0; c < 4; c++) begin
            in_valid = (idx < 4);
            add_out0 = (idx < 4) ? bp_a[idx] : 32'h0;
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("bp_rate", 64'(n_dlv - d0), 64'd4);
        check("bp_all_in", 64'(idx), 64'd4);
        drain();

        // Random traffic; data held stable while a request is pending.
        acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1) begin
                    add_out0 = $urandom;
                    add_out1 = $urandom;
                end else begin
                    add_out0 = $urandom & 32'h3FFFFFFF;
                    add_out1 = $urandom & 32'h0000FFFF;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Reset with two entries in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        add_out0  = 32'h40000000;
        add_out1  = 32'h0;
        step();
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sat_cnt", 64'(sat_cnt), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        d0 = n_dlv;
        repeat (5) step();
        check("mid_rst_no_stale", 64'(n_dlv - d0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
